test_ram_b: RTL and testbench
=============================

Name: test_ram_b

Overview:
- Board-level RAM exercise block: a 64 x 32-bit word-addressed data memory.
- Writes a fixed 32-bit pattern to the addressed word.
- Shows one selected byte of the addressed word on 8 LEDs.
- Sits between board switches (address, write, byte select) and the LED bank; used to verify the memory datapath on the FPGA.

Parameters:
- WRITE_DATA, 32'h1234_5678, value stored on every write.
- DEPTH, 64, number of 32-bit words; fixed by the 6-bit address.

Ports:
- Clk  input  1  system clock; rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- Mem_Addr  input  6 (bits [7:2])  word address; byte address bits [1:0] are implicitly 00.
- C  input  2  byte select for LED display.
- Mem_Write  input  1  write enable.
- LED  output  8  selected byte of the addressed word.

Behaviour:
- Clocking and reset: one clock domain (Clk); Reset is asynchronous and active-high.
- Storage: mem[0..63], 32 bits each.
- Reset:
  - On Reset high, immediately and independent of Clk, all 64 words clear to 0.
  - LED therefore reads 8'h00 during and after reset until a write occurs.
  - Reset dominates any write on the same edge.
- Write:
  - On rising Clk with Reset=0 and Mem_Write=1, mem[Mem_Addr] <= WRITE_DATA.
  - No other word changes.
  - Mem_Write=0: memory holds.
  - Writes are always full 32-bit words; C does not affect writes.
- Read:
  - Combinational, asynchronous: rdata = mem[Mem_Addr].
  - A change on Mem_Addr or C propagates to LED with no clock.
- Byte select:
  - C=00 -> LED = rdata[7:0]
  - C=01 -> LED = rdata[15:8]
  - C=10 -> LED = rdata[23:16]
  - C=11 -> LED = rdata[31:24]
  - Little-endian byte numbering.
- Read during write: before the edge, LED shows the old word. Immediately after the edge, LED shows WRITE_DATA for the written address.
- Address wrap: all 64 addresses are valid; no out-of-range case exists.
- Repeated writes to the same address are idempotent.
- No handshake, no busy state; one write per clock at most.

Optional Feature:
- Macro: TEST_RAM_B_LED_REG_EN
- Defined:
  - LED is registered: LED <= selected byte on each rising Clk.
  - Asynchronous reset drives LED to 8'h00.
  - Display lags Mem_Addr/C/memory changes by one clock.
  - A write and a read of the same address on the same edge registers the old data; the new data appears on the next edge.
- Undefined: LED is purely combinational, as described under Behaviour.

Test Plan:
- Reset: assert Reset with any address and C=00..11 -> LED=8'h00 for every address.
- Write/readback: Mem_Addr=6'b100000, Mem_Write=1, C=10, one Clk rising edge:
  - C=10 -> LED=8'h34
  - C=01 -> LED=8'h56
  - C=00 -> LED=8'h78
  - C=11 -> LED=8'h12
- No-write hold: Mem_Write=0, clock several edges at address 6'b000001 -> LED stays 8'h00 for all C.
- Isolation: after writing address 32, read addresses 31 and 33 -> LED=8'h00. Address 32 still shows 8'h12 with C=11.
- Async reset mid-operation: after the write, pulse Reset between clock edges -> LED drops to 8'h00 at once. A Clk edge with Mem_Write=1 while Reset is high -> no write.
- Optional feature (macro defined): change C from 01 to 10 after a write -> LED holds 8'h56 until the next Clk edge, then shows 8'h34.

Source files
------------

// File: rtl/test_ram_b.sv
// test_ram_b: board RAM exercise block. A 64 x 32-bit word memory written with a
// fixed pattern, with one byte of the addressed word shown on the LED bank.
// Optional macro TEST_RAM_B_LED_REG_EN registers the LED output (one-clock lag).
module test_ram_b #(
   parameter logic [31:0] WRITE_DATA = 32'h1234_5678,
   parameter int unsigned DEPTH      = 64
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Mem_Addr,
   input  logic [1:0] C,
   input  logic       Mem_Write,
   output logic [7:0] LED
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];
   logic [31:0] rdata;
   logic [7:0]  led_sel;

   // Next memory state: only the addressed word takes the pattern on a write
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (Mem_Write) begin
         mem_d[Mem_Addr] = WRITE_DATA;
      end
   end

   // Storage flops; asynchronous reset clears every word and wins over a write
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Asynchronous read and little-endian byte select
   always_comb begin
      rdata = mem_q[Mem_Addr];
      case (C)
         2'b00:   led_sel = rdata[7:0];
         2'b01:   led_sel = rdata[15:8];
         2'b10:   led_sel = rdata[23:16];
         default: led_sel = rdata[31:24];
      endcase
   end

`ifdef TEST_RAM_B_LED_REG_EN
   logic [7:0] led_q;
   logic [7:0] led_d;

   // Registered display samples pre-edge memory, so a same-edge write shows next clock
   always_comb begin
      led_d = led_sel;
   end

   // LED register with asynchronous clear
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign LED = led_q;
`else
   assign LED = led_sel;
`endif

endmodule

// File: tb/tb_test_ram_b.sv
// tb_test_ram_b: self-checking bench for test_ram_b with a behavioural word-array model.
module tb_test_ram_b;

   localparam logic [31:0] WD = 32'h1234_5678;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [5:0] Mem_Addr;
   logic [1:0] C;
   logic       Mem_Write;
   logic [7:0] LED;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   // Reference model: plain word array plus the registered display value
   logic [31:0] model [64];
   logic [7:0]  led_model;

   test_ram_b #(.WRITE_DATA(WD), .DEPTH(64)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Mem_Addr  (Mem_Addr),
      .C         (C),
      .Mem_Write (Mem_Write),
      .LED       (LED)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] comb_led();
      logic [31:0] w;
      w = model[Mem_Addr];
      return 8'((w >> (8 * C)) & 32'hFF);
   endfunction

   function automatic logic [7:0] expected();
`ifdef TEST_RAM_B_LED_REG_EN
      return led_model;
`else
      return comb_led();
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 64; i++) model[i] = '0;
      led_model = '0;
   endtask

   task automatic tick();
      logic [7:0] pre;
      pre = comb_led();
      @(posedge Clk);
      if (!Reset) begin
         if (Mem_Write) model[Mem_Addr] = WD;
         led_model = pre;
      end
      #1;
   endtask

   // Let the display reflect current Mem_Addr/C without writing
   task automatic settle();
      Mem_Write = 1'b0;
`ifdef TEST_RAM_B_LED_REG_EN
      tick();
`else
      #1;
`endif
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Mem_Write = 1'b1;
      Mem_Addr = '0;
      C = '0;
      clear_model();
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         Mem_Addr = 6'($urandom_range(0, 63));
         for (int c = 0; c < 4; c++) begin
            C = 2'(c);
            #1;
            total_cnt++;
            if (LED !== 8'h00) $display("FAIL reset addr=%0d C=%0d LED=%h exp=00", Mem_Addr, C, LED);
            else pass_cnt++;
         end
      end
      Mem_Write = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_write_readback();
      logic [1:0] cs  [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
      logic [7:0] exp [4] = '{8'h34, 8'h56, 8'h78, 8'h12};
      Mem_Addr = 6'd32;
      C = 2'b10;
      Mem_Write = 1'b1;
      tick();
      Mem_Write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         C = cs[i];
         settle();
         total_cnt++;
         if (LED !== exp[i]) $display("FAIL write_readback C=%0d LED=%h exp=%h", C, LED, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_no_write_hold();
      Mem_Addr = 6'd1;
      Mem_Write = 1'b0;
      repeat (4) tick();
      for (int c = 0; c < 4; c++) begin
         C = 2'(c);
         settle();
         total_cnt++;
         if (LED !== 8'h00) $display("FAIL no_write_hold C=%0d LED=%h exp=00", C, LED);
         else pass_cnt++;
      end
   endtask

   task automatic test_isolation();
      logic [5:0] addrs [2] = '{6'd31, 6'd33};
      foreach (addrs[a]) begin
         Mem_Addr = addrs[a];
         for (int c = 0; c < 4; c++) begin
            C = 2'(c);
            settle();
            total_cnt++;
            if (LED !== 8'h00) $display("FAIL isolation addr=%0d C=%0d LED=%h exp=00", Mem_Addr, C, LED);
            else pass_cnt++;
         end
      end
      Mem_Addr = 6'd32;
      C = 2'b11;
      settle();
      total_cnt++;
      if (LED !== 8'h12) $display("FAIL isolation_addr32 LED=%h exp=12", LED);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      Mem_Addr = 6'd32;
      C = 2'b11;
      settle();
      total_cnt++;
      if (LED !== 8'h12) $display("FAIL async_reset_pre LED=%h exp=12", LED);
      else pass_cnt++;
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      clear_model();
      #1;
      total_cnt++;
      if (LED !== 8'h00) $display("FAIL async_reset_immediate LED=%h exp=00", LED);
      else pass_cnt++;
      Mem_Write = 1'b1;
      tick();
      @(negedge Clk);
      Mem_Write = 1'b0;
      Reset = 1'b0;
      settle();
      total_cnt++;
      if (LED !== 8'h00) $display("FAIL async_reset_blocks_write LED=%h exp=00", LED);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         Mem_Addr = 6'($urandom_range(0, 63));
         C = 2'($urandom_range(0, 3));
         Mem_Write = ($urandom_range(0, 9) < 3);
         tick();
         total_cnt++;
         if (LED !== expected()) $display("FAIL random_edge addr=%0d C=%0d LED=%h exp=%h", Mem_Addr, C, LED, expected());
         else pass_cnt++;
         Mem_Write = 1'b0;
         Mem_Addr = 6'($urandom_range(0, 63));
         C = 2'($urandom_range(0, 3));
         #1;
         total_cnt++;
         if (LED !== expected()) $display("FAIL random_mid addr=%0d C=%0d LED=%h exp=%h", Mem_Addr, C, LED, expected());
         else pass_cnt++;
      end
   endtask

`ifdef TEST_RAM_B_LED_REG_EN
   task automatic test_led_reg();
      Reset = 1'b1;
      clear_model();
      #1;
      @(negedge Clk);
      Reset = 1'b0;
      Mem_Addr = 6'd32;
      C = 2'b01;
      Mem_Write = 1'b1;
      tick();
      total_cnt++;
      if (LED !== 8'h00) $display("FAIL led_reg_same_edge LED=%h exp=00", LED);
      else pass_cnt++;
      Mem_Write = 1'b0;
      tick();
      total_cnt++;
      if (LED !== 8'h56) $display("FAIL led_reg_next_edge LED=%h exp=56", LED);
      else pass_cnt++;
      C = 2'b10;
      #1;
      total_cnt++;
      if (LED !== 8'h56) $display("FAIL led_reg_hold LED=%h exp=56", LED);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (LED !== 8'h34) $display("FAIL led_reg_update LED=%h exp=34", LED);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_write_readback();
      test_no_write_hold();
      test_isolation();
      test_async_reset();
      test_random();
`ifdef TEST_RAM_B_LED_REG_EN
      test_led_reg();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
